// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - SPI master serial engine: one DATA_WIDTH frame per trigger, per-frame CPOL/CPHA, ready pulse at frame end
module spi_master_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SS     = 10,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] command,
    input  logic [NUM_SS-1:0]     ss,
    input  logic                  trigger,
    input  logic                  CPOL,
    input  logic                  CPHA,
    output logic                  ready,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SS-1:0]     ss_n,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGES  = 2 * DATA_WIDTH;
    localparam int EDGE_W = $clog2(EDGES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [EDGE_W-1:0]     r_edge;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [NUM_SS-1:0]     r_ss_n;
    logic                  r_cpha;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_ready;
    logic                  r_rx_valid;

    logic w_cnt_done;
    logic w_accept;
    logic w_edge;
    logic w_sample;
    logic w_last_edge;

    assign w_cnt_done  = (r_cnt == CNT_LAST);
    // The ready cycle already sits in IDLE, so a trigger there must still be refused.
    assign w_accept    = (r_state == S_IDLE) && trigger && !r_ready;
    assign w_edge      = ((r_state == S_LEAD) || (r_state == S_SHIFT)) && w_cnt_done;
    assign w_sample    = (~r_edge[0]) ^ r_cpha;
    assign w_last_edge = (r_edge == EDGE_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_LEAD;
            S_LEAD:  if (w_cnt_done) w_next_state = S_SHIFT;
            S_SHIFT: if (w_cnt_done && w_last_edge) w_next_state = S_TRAIL;
            S_TRAIL: if (w_cnt_done) w_next_state = S_GAP;
            S_GAP:   if (w_cnt_done) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_edge     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_ss_n     <= '1;
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ready    <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_rx_valid <= 1'b0;

            if ((r_state == S_IDLE) || w_cnt_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_cpha <= CPHA;
                r_ss_n <= ~ss;
                r_sclk <= CPOL;
                r_edge <= '0;
                // CPHA=0 presents the MSB now, so the shifter starts one bit ahead.
                if (!CPHA) begin
                    r_mosi <= command[DATA_WIDTH-1];
                    r_tx   <= {command[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    r_tx   <= command;
                end
            end

            if (w_edge) begin
                r_sclk <= ~r_sclk;
                r_edge <= r_edge + EDGE_W'(1);
                if (w_sample) begin
                    r_rx <= {r_rx[DATA_WIDTH-2:0], miso};
                end else if (r_cpha || !w_last_edge) begin
                    r_mosi <= r_tx[DATA_WIDTH-1];
                    r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                end
            end

            if ((r_state == S_TRAIL) && w_cnt_done) begin
                r_ss_n <= '1;
                r_mosi <= 1'b0;
            end

            if ((r_state == S_GAP) && w_cnt_done) begin
                r_ready    <= 1'b1;
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_rx;
            end
        end
    end

    assign ready    = r_ready;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state != S_IDLE) || r_ready;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign ss_n     = r_ss_n;
    assign rx_data  = r_rx_data;

endmodule
